// File: rtl/simd_alu_pipe.sv
// rtl/simd_alu_pipe.sv - 2-stage pipelined SIMD ALU, 8/16/32/64-bit lanes, bit 0 = MSB
// Optional per-lane ADD/SUB saturation when SIMD_ALU_SAT_EN is defined.
module simd_alu_pipe #(
  parameter int         DATA_W    = 64,
  parameter logic [5:0] R_ALU_OPC = 6'b101010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:5]        op_code,
  input  logic [0:5]        r_ins,
  input  logic [1:0]        ww,
  input  logic [0:DATA_W-1] ra_val,
  input  logic [0:DATA_W-1] rb_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] alu_out,
  output logic              out_err,
  output logic              out_sat
);
  localparam logic [5:0] F_AND = 6'b000001, F_OR = 6'b000010, F_XOR = 6'b000011;
  localparam logic [5:0] F_NOT = 6'b000100, F_MOV = 6'b000101, F_ADD = 6'b000110;
  localparam logic [5:0] F_SUB = 6'b000111, F_MULEU = 6'b001000, F_MULOU = 6'b001001;
  localparam logic [5:0] F_SLL = 6'b001010, F_SRL = 6'b001011, F_SRA = 6'b001100;

  // Internal vectors are little-endian; MSB-first lane 0 sits at the top bits.
  logic [DATA_W-1:0] w_a, w_b;
  logic [5:0]        w_fn;
  assign w_a  = ra_val;
  assign w_b  = rb_val;
  assign w_fn = r_ins;

  for (genvar g = 0; g < 4; g++) begin : g_w
    localparam int W  = 8 << g;
    localparam int N  = DATA_W / W;
    localparam int SW = g + 3;
    logic [DATA_W-1:0] w_res;
    logic [DATA_W-1:0] w_mul;
`ifdef SIMD_ALU_SAT_EN
    logic [N-1:0] w_sat_l;
    logic         w_sat_any;
    assign w_sat_any = |w_sat_l;
`endif
    for (genvar k = 0; k < N; k++) begin : g_l
      logic [W-1:0]  w_la, w_lb, w_lr;
      logic [SW-1:0] w_amt;
`ifdef SIMD_ALU_SAT_EN
      logic [W:0]    w_sum, w_dif;
      logic          w_ls;
      assign w_sum = {1'b0, w_la} + {1'b0, w_lb};
      assign w_dif = {1'b0, w_la} - {1'b0, w_lb};
      assign w_sat_l[k] = w_ls;
`else
      logic [W-1:0]  w_sum, w_dif;
      assign w_sum = w_la + w_lb;
      assign w_dif = w_la - w_lb;
`endif
      assign w_la  = w_a[k*W +: W];
      assign w_lb  = w_b[k*W +: W];
      assign w_amt = w_lb[SW-1:0];
      always_comb begin
        w_lr = '0;
        case (w_fn)
          F_ADD:   w_lr = w_sum[W-1:0];
          F_SUB:   w_lr = w_dif[W-1:0];
          F_SLL:   w_lr = w_la << w_amt;
          F_SRL:   w_lr = w_la >> w_amt;
          F_SRA:   w_lr = $signed(w_la) >>> w_amt;
          default: w_lr = '0;
        endcase
`ifdef SIMD_ALU_SAT_EN
        w_ls = 1'b0;
        if (w_fn == F_ADD && w_sum[W]) begin
          w_lr = '1;
          w_ls = 1'b1;
        end
        if (w_fn == F_SUB && w_dif[W]) begin
          w_lr = '0;
          w_ls = 1'b1;
        end
`endif
      end
      assign w_res[k*W +: W] = w_lr;
    end
    if (g < 3) begin : g_m
      // Each 2W field: upper half is the even (MSB-first) lane, lower half the odd lane.
      for (genvar j = 0; j < N / 2; j++) begin : g_f
        logic [W-1:0] w_ma, w_mb;
        assign w_ma = (w_fn == F_MULOU) ? w_a[2*j*W +: W] : w_a[(2*j+1)*W +: W];
        assign w_mb = (w_fn == F_MULOU) ? w_b[2*j*W +: W] : w_b[(2*j+1)*W +: W];
        assign w_mul[2*j*W +: 2*W] = {{W{1'b0}}, w_ma} * {{W{1'b0}}, w_mb};
      end
    end else begin : g_nm
      assign w_mul = '0;
    end
  end

  logic [DATA_W-1:0] w_lane_res, w_mul_res, w_s1_res;
  logic              w_is_r, w_mul_op, w_legal, w_err, w_mul_ok, w_adv;
  always_comb begin
    case (ww)
      2'b00:   begin w_lane_res = g_w[0].w_res; w_mul_res = g_w[0].w_mul; end
      2'b01:   begin w_lane_res = g_w[1].w_res; w_mul_res = g_w[1].w_mul; end
      2'b10:   begin w_lane_res = g_w[2].w_res; w_mul_res = g_w[2].w_mul; end
      default: begin w_lane_res = g_w[3].w_res; w_mul_res = g_w[3].w_mul; end
    endcase
  end

  assign w_is_r   = (op_code == R_ALU_OPC);
  assign w_mul_op = (w_fn == F_MULEU) || (w_fn == F_MULOU);
  assign w_legal  = (w_fn <= F_SRA) && !(w_mul_op && ww == 2'b11);
  assign w_err    = w_is_r && !w_legal;
  assign w_mul_ok = w_is_r && w_legal && w_mul_op;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_s1_res = '0;
    if (w_is_r && w_legal) begin
      case (w_fn)
        F_AND:                       w_s1_res = w_a & w_b;
        F_OR:                        w_s1_res = w_a | w_b;
        F_XOR:                       w_s1_res = w_a ^ w_b;
        F_NOT:                       w_s1_res = ~w_a;
        F_MOV:                       w_s1_res = w_a;
        F_ADD, F_SUB, F_SLL, F_SRL,
        F_SRA:                       w_s1_res = w_lane_res;
        default:                     w_s1_res = '0;
      endcase
    end
  end

  logic              r1_valid, r1_mul, r1_err;
  logic [DATA_W-1:0] r1_res, r1_prod;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_res   <= '0;
      r1_prod  <= '0;
      r1_mul   <= 1'b0;
      r1_err   <= 1'b0;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      r1_res   <= in_valid ? w_s1_res : '0;
      r1_prod  <= in_valid ? w_mul_res : '0;
      r1_mul   <= in_valid & w_mul_ok;
      r1_err   <= in_valid & w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      out_err   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r1_valid;
      alu_out   <= r1_mul ? r1_prod : r1_res;
      out_err   <= r1_err;
    end
  end

`ifdef SIMD_ALU_SAT_EN
  logic w_lane_sat, r1_sat;
  always_comb begin
    case (ww)
      2'b00:   w_lane_sat = g_w[0].w_sat_any;
      2'b01:   w_lane_sat = g_w[1].w_sat_any;
      2'b10:   w_lane_sat = g_w[2].w_sat_any;
      default: w_lane_sat = g_w[3].w_sat_any;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_sat  <= 1'b0;
      out_sat <= 1'b0;
    end else if (w_adv) begin
      r1_sat  <= in_valid & w_is_r & w_legal & w_lane_sat;
      out_sat <= r1_sat;
    end
  end
`else
  assign out_sat = 1'b0;
`endif
endmodule
